// File: rtl/gain_relay_scheduler.sv
// Front-end gain relay scheduler: arbitrates between the auto-gain loop and a
// host override, then sequences each relay change through settle (ADC blanked)
// and a minimum dwell before the next non-urgent switch.
module gain_relay_scheduler #(
  parameter int         SETTLE_CYCLES = 200000,
  parameter int         DWELL_CYCLES  = 2000000,
  parameter int         CNT_W         = 24,
  parameter logic [1:0] INIT_GAIN     = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       manual_en,
  input  logic       manual_req,
  input  logic [1:0] manual_gain,
  input  logic       auto_req,
  input  logic [1:0] auto_gain,
  input  logic       auto_urgent,
  output logic       manual_ack,
  output logic       auto_ack,
  output logic [1:0] relay_ctrl,
  output logic       blank,
  output logic       gain_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       relay_q, relay_d;
  logic             blank_q, blank_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             mack_q, mack_d;
  logic             aack_q, aack_d;

  // Only one requester is eligible at a time; the host wins while manual_en is set.
  logic       elig_req;
  logic [1:0] elig_gain;
  logic       urgent_down;

  assign elig_req    = manual_en ? manual_req : auto_req;
  assign elig_gain   = manual_en ? manual_gain : auto_gain;
  // Overvoltage may cut dwell short, but only to step gain down.
  assign urgent_down = !manual_en && auto_req && auto_urgent && (auto_gain < relay_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    relay_d = relay_q;
    blank_d = blank_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    mack_d  = 1'b0;
    aack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig_req) begin
          mack_d = manual_en;
          aack_d = !manual_en;
          if (elig_gain != relay_q) begin
            relay_d = elig_gain;
            blank_d = 1'b1;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          blank_d = 1'b0;
          valid_d = 1'b1;
          cnt_d   = DWELL_LOAD;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWELL: begin
        if (urgent_down) begin
          aack_d  = 1'b1;
          relay_d = auto_gain;
          blank_d = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
        blank_d = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State registers; reset forces a fresh settle at the initial gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= SETTLE_LOAD;
      relay_q <= INIT_GAIN;
      blank_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      mack_q  <= 1'b0;
      aack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      relay_q <= relay_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      mack_q  <= mack_d;
      aack_q  <= aack_d;
    end
  end

  assign manual_ack = mack_q;
  assign auto_ack   = aack_q;
  assign relay_ctrl = relay_q;
  assign blank      = blank_q;
  assign gain_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gain_relay_scheduler.sv
// Directed bench for gain_relay_scheduler with short settle/dwell times.
module tb_gain_relay_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       manual_en = 1'b0;
  logic       manual_req = 1'b0;
  logic [1:0] manual_gain = 2'd0;
  logic       auto_req = 1'b0;
  logic [1:0] auto_gain = 2'd0;
  logic       auto_urgent = 1'b0;
  logic       manual_ack, auto_ack, blank, gain_valid, busy;
  logic [1:0] relay_ctrl;

  int vectors = 0;
  int miscompares = 0;

  gain_relay_scheduler #(
    .SETTLE_CYCLES(8),
    .DWELL_CYCLES (16),
    .CNT_W        (5),
    .INIT_GAIN    (2'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .manual_en  (manual_en),
    .manual_req (manual_req),
    .manual_gain(manual_gain),
    .auto_req   (auto_req),
    .auto_gain  (auto_gain),
    .auto_urgent(auto_urgent),
    .manual_ack (manual_ack),
    .auto_ack   (auto_ack),
    .relay_ctrl (relay_ctrl),
    .blank      (blank),
    .gain_valid (gain_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the chosen output (0=blank, 1=busy, 2=auto_ack, 3=manual_ack)
  // reaches the target level; n = ticks taken, capped at 100.
  task automatic ticks_until(input int which, input logic level, output int n);
    logic s;
    n = 0;
    do begin
      tick();
      n++;
      case (which)
        0: s = blank;
        1: s = busy;
        2: s = auto_ack;
        default: s = manual_ack;
      endcase
    end while (s !== level && n < 100);
  endtask

  task automatic test_reset();
    int n;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (relay_ctrl !== 2'd0 || blank !== 1'b1 || gain_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: relay=%0d blank=%b gv=%b busy=%b, want 0 1 0 1",
               relay_ctrl, blank, gain_valid, busy);
    end
    tick();
    vectors++;
    if (manual_ack !== 1'b0 || auto_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_acks: mack=%b aack=%b, want 0 0", manual_ack, auto_ack);
    end
    rst = 1'b0;
    ticks_until(0, 1'b0, n);
    vectors++;
    if (n !== 8 || gain_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_settle: blank cycles=%0d gv=%b, want 8 1", n, gain_valid);
    end
    ticks_until(1, 1'b0, n);
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL reset_dwell: busy cycles after settle=%0d, want 16", n);
    end
  endtask

  task automatic test_auto_switch();
    int n;
    manual_en = 1'b0; auto_req = 1'b1; auto_gain = 2'd2; auto_urgent = 1'b0;
    tick();
    vectors++;
    if (auto_ack !== 1'b1 || manual_ack !== 1'b0 || relay_ctrl !== 2'd2 ||
        blank !== 1'b1 || gain_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_accept: aack=%b mack=%b relay=%0d blank=%b gv=%b busy=%b, want 1 0 2 1 0 1",
               auto_ack, manual_ack, relay_ctrl, blank, gain_valid, busy);
    end
    auto_req = 1'b0;
    tick();
    vectors++;
    if (auto_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_ack_pulse: aack=%b, want 0", auto_ack);
    end
    ticks_until(0, 1'b0, n);
    vectors++;
    if (n + 1 !== 7 + 1) begin
      miscompares++;
      $display("FAIL auto_blank_len: blank cycles=%0d, want 8", n + 1);
    end
    ticks_until(1, 1'b0, n);
    vectors++;
    if (n + 8 !== 24) begin
      miscompares++;
      $display("FAIL auto_busy_len: busy cycles=%0d, want 24", n + 8);
    end
  endtask

  task automatic test_dwell_hold();
    int n;
    auto_req = 1'b1; auto_gain = 2'd1;
    tick();
    auto_req = 1'b0;
    ticks_until(0, 1'b0, n);
    auto_req = 1'b1; auto_gain = 2'd3;
    ticks_until(2, 1'b1, n);
    vectors++;
    if (n !== 17 || relay_ctrl !== 2'd3) begin
      miscompares++;
      $display("FAIL dwell_hold: ack after %0d cycles relay=%0d, want 17 3", n, relay_ctrl);
    end
    auto_req = 1'b0;
  endtask

  task automatic test_urgent();
    int n;
    ticks_until(0, 1'b0, n);
    auto_req = 1'b1; auto_gain = 2'd1; auto_urgent = 1'b1;
    tick();
    vectors++;
    if (auto_ack !== 1'b1 || relay_ctrl !== 2'd1 || blank !== 1'b1) begin
      miscompares++;
      $display("FAIL urgent_down: aack=%b relay=%0d blank=%b, want 1 1 1", auto_ack, relay_ctrl, blank);
    end
    auto_req = 1'b0;
    ticks_until(0, 1'b0, n);
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL urgent_blank_len: blank cycles=%0d, want 8", n);
    end
    auto_req = 1'b1; auto_gain = 2'd3;
    ticks_until(2, 1'b1, n);
    vectors++;
    if (n !== 17 || relay_ctrl !== 2'd3) begin
      miscompares++;
      $display("FAIL urgent_up_held: ack after %0d cycles relay=%0d, want 17 3", n, relay_ctrl);
    end
    auto_req = 1'b0; auto_urgent = 1'b0;
    ticks_until(1, 1'b0, n);
  endtask

  task automatic test_manual();
    int n;
    manual_en = 1'b1;
    manual_req = 1'b1; manual_gain = 2'd1;
    auto_req = 1'b1; auto_gain = 2'd2;
    tick();
    vectors++;
    if (manual_ack !== 1'b1 || auto_ack !== 1'b0 || relay_ctrl !== 2'd1) begin
      miscompares++;
      $display("FAIL manual_priority: mack=%b aack=%b relay=%0d, want 1 0 1",
               manual_ack, auto_ack, relay_ctrl);
    end
    manual_req = 1'b0;
    ticks_until(1, 1'b0, n);
    vectors++;
    if (auto_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL manual_auto_ignored: aack=%b, want 0", auto_ack);
    end
    auto_req = 1'b0;
    manual_req = 1'b1;
    tick();
    vectors++;
    if (manual_ack !== 1'b1 || blank !== 1'b0 || busy !== 1'b0 ||
        gain_valid !== 1'b1 || relay_ctrl !== 2'd1) begin
      miscompares++;
      $display("FAIL manual_same_gain: mack=%b blank=%b busy=%b gv=%b relay=%0d, want 1 0 0 1 1",
               manual_ack, blank, busy, gain_valid, relay_ctrl);
    end
    manual_req = 1'b0;
    tick();
    vectors++;
    if (manual_ack !== 1'b0 || blank !== 1'b0) begin
      miscompares++;
      $display("FAIL manual_same_gain_after: mack=%b blank=%b, want 0 0", manual_ack, blank);
    end
  endtask

  task automatic test_owner_toggle();
    int n;
    manual_req = 1'b1; manual_gain = 2'd2;
    tick();
    manual_req = 1'b0;
    tick();
    manual_en = 1'b0;
    ticks_until(0, 1'b0, n);
    vectors++;
    if (n + 1 !== 8 || relay_ctrl !== 2'd2) begin
      miscompares++;
      $display("FAIL toggle_settle: blank cycles=%0d relay=%0d, want 8 2", n + 1, relay_ctrl);
    end
    ticks_until(1, 1'b0, n);
    manual_req = 1'b1; manual_gain = 2'd3;
    auto_req = 1'b1; auto_gain = 2'd0;
    tick();
    vectors++;
    if (auto_ack !== 1'b1 || manual_ack !== 1'b0 || relay_ctrl !== 2'd0) begin
      miscompares++;
      $display("FAIL toggle_new_owner: aack=%b mack=%b relay=%0d, want 1 0 0",
               auto_ack, manual_ack, relay_ctrl);
    end
    manual_req = 1'b0; auto_req = 1'b0;
  endtask

  task automatic test_midrun_reset();
    int n;
    ticks_until(1, 1'b0, n);
    auto_req = 1'b1; auto_gain = 2'd3;
    tick();
    auto_req = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (relay_ctrl !== 2'd0 || blank !== 1'b1 || busy !== 1'b1 || gain_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: relay=%0d blank=%b busy=%b gv=%b, want 0 1 1 0",
               relay_ctrl, blank, busy, gain_valid);
    end
    tick();
    rst = 1'b0;
    ticks_until(0, 1'b0, n);
    vectors++;
    if (n !== 8 || gain_valid !== 1'b1 || relay_ctrl !== 2'd0) begin
      miscompares++;
      $display("FAIL midrun_settle: blank cycles=%0d gv=%b relay=%0d, want 8 1 0",
               n, gain_valid, relay_ctrl);
    end
    ticks_until(1, 1'b0, n);
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL midrun_dwell: busy cycles after settle=%0d, want 16", n);
    end
  endtask

  initial begin
    test_reset();
    test_auto_switch();
    test_dwell_hold();
    test_urgent();
    test_manual();
    test_owner_toggle();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
